// File: rtl/peripheral_esp_ctrl_multi.sv
// peripheral_esp_ctrl_multi: bus-mapped power-on sequencer for up to 8 ESP-class modules.
// Each channel drives its module reset for PULSE_LEN cycles, waits BOOT_LEN cycles,
// then reports READY and latches a DONE flag that can raise irq.
// Legal parameter range: 1 <= N_CH <= 8, 1 <= CNT_W <= 16.
module peripheral_esp_ctrl_multi #(
  parameter int N_CH      = 2,
  parameter int CNT_W     = 16,
  parameter int PULSE_DEF = 50,
  parameter int BOOT_DEF  = 100
) (
  input  logic            clk,
  input  logic            sys_rst,
  input  logic            cs,
  input  logic            rd,
  input  logic            wr,
  input  logic [3:0]      addr,
  input  logic [15:0]     d_in,
  output logic [15:0]     d_out,
  output logic [N_CH-1:0] mod_rst,
  output logic [N_CH-1:0] ready,
  output logic            irq
);

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h2;
  localparam logic [3:0] ADDR_PULSE  = 4'h4;
  localparam logic [3:0] ADDR_BOOT   = 4'h6;
  localparam logic [3:0] ADDR_DONE   = 4'h8;
  localparam logic [3:0] ADDR_IRQ_EN = 4'hA;

  localparam logic [CNT_W-1:0] ONE            = CNT_W'(1);
  localparam logic [CNT_W-1:0] PULSE_RST      = CNT_W'(PULSE_DEF);
  localparam logic [CNT_W-1:0] BOOT_RST       = CNT_W'(BOOT_DEF);
  localparam logic [CNT_W-1:0] PULSE_LOAD_RST = (PULSE_RST == '0) ? ONE : PULSE_RST;

  // ST_IDLE only exists for unused channel slots; instantiated channels never reach it.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RST,
    ST_BOOT,
    ST_READY
  } state_e;

  state_e           state_q     [N_CH];
  state_e           state_d     [N_CH];
  logic [CNT_W-1:0] cnt_q       [N_CH];
  logic [CNT_W-1:0] cnt_d       [N_CH];
  logic [CNT_W-1:0] boot_snap_q [N_CH];
  logic [CNT_W-1:0] boot_snap_d [N_CH];

  logic [CNT_W-1:0] pulse_len_q, pulse_len_d;
  logic [CNT_W-1:0] boot_len_q, boot_len_d;
  logic [N_CH-1:0]  done_q, done_d;
  logic [N_CH-1:0]  irq_en_q, irq_en_d;
  logic [N_CH-1:0]  mod_rst_q, mod_rst_d;
  logic [N_CH-1:0]  ready_q, ready_d;
  logic [15:0]      d_out_q, d_out_d;

  logic             wr_en;
  logic             rd_en;
  logic [N_CH-1:0]  start;
  logic [N_CH-1:0]  clear;
  logic [N_CH-1:0]  enter_ready;
  logic [N_CH-1:0]  busy;
  logic [CNT_W-1:0] pulse_load;
  logic [15:0]      rdata;

  // Bus write decode: register updates, channel start strobes and DONE clear mask.
  always_comb begin
    wr_en       = cs & wr;
    rd_en       = cs & rd;
    start       = '0;
    clear       = '0;
    pulse_len_d = pulse_len_q;
    boot_len_d  = boot_len_q;
    irq_en_d    = irq_en_q;
    if (wr_en) begin
      case (addr)
        ADDR_CTRL:   start       = d_in[N_CH-1:0];
        ADDR_PULSE:  pulse_len_d = d_in[CNT_W-1:0];
        ADDR_BOOT:   boot_len_d  = d_in[CNT_W-1:0];
        ADDR_DONE:   clear       = d_in[N_CH-1:0];
        ADDR_IRQ_EN: irq_en_d    = d_in[N_CH-1:0];
        default:     ;
      endcase
    end
    pulse_load = (pulse_len_q == '0) ? ONE : pulse_len_q;
  end

  // Per-channel sequencer; BOOT_LEN is snapshotted at start so later writes cannot stretch
  // or shorten a sequence already in flight.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      state_d[i]     = state_q[i];
      cnt_d[i]       = cnt_q[i];
      boot_snap_d[i] = boot_snap_q[i];
      enter_ready[i] = 1'b0;
      busy[i]        = (state_q[i] == ST_RST) || (state_q[i] == ST_BOOT);
      if (start[i]) begin
        state_d[i]     = ST_RST;
        cnt_d[i]       = pulse_load;
        boot_snap_d[i] = boot_len_q;
      end else begin
        case (state_q[i])
          ST_RST: begin
            if (cnt_q[i] <= ONE) begin
              state_d[i] = ST_BOOT;
              cnt_d[i]   = boot_snap_q[i];
            end else begin
              cnt_d[i] = cnt_q[i] - ONE;
            end
          end
          ST_BOOT: begin
            if (cnt_q[i] <= ONE) begin
              state_d[i]     = ST_READY;
              cnt_d[i]       = '0;
              enter_ready[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] - ONE;
            end
          end
          default: ;
        endcase
      end
      mod_rst_d[i] = (state_d[i] == ST_RST);
      ready_d[i]   = (state_d[i] == ST_READY);
    end
    done_d = (done_q & ~clear) | enter_ready;
  end

  // Read mux built from pre-edge register values, so a combined read/write returns old data.
  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_STATUS: begin
        rdata[N_CH-1:0]  = ready_q;
        rdata[8 +: N_CH] = busy;
      end
      ADDR_PULSE:  rdata[CNT_W-1:0] = pulse_len_q;
      ADDR_BOOT:   rdata[CNT_W-1:0] = boot_len_q;
      ADDR_DONE:   rdata[N_CH-1:0]  = done_q;
      ADDR_IRQ_EN: rdata[N_CH-1:0]  = irq_en_q;
      default:     ;
    endcase
    d_out_d = rd_en ? rdata : d_out_q;
  end

  // All state, registered outputs included; sys_rst restarts every channel in RST.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i]     <= ST_RST;
        cnt_q[i]       <= PULSE_LOAD_RST;
        boot_snap_q[i] <= BOOT_RST;
      end
      pulse_len_q <= PULSE_RST;
      boot_len_q  <= BOOT_RST;
      done_q      <= '0;
      irq_en_q    <= '0;
      mod_rst_q   <= '1;
      ready_q     <= '0;
      d_out_q     <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i]     <= state_d[i];
        cnt_q[i]       <= cnt_d[i];
        boot_snap_q[i] <= boot_snap_d[i];
      end
      pulse_len_q <= pulse_len_d;
      boot_len_q  <= boot_len_d;
      done_q      <= done_d;
      irq_en_q    <= irq_en_d;
      mod_rst_q   <= mod_rst_d;
      ready_q     <= ready_d;
      d_out_q     <= d_out_d;
    end
  end

  assign mod_rst = mod_rst_q;
  assign ready   = ready_q;
  assign d_out   = d_out_q;
  assign irq     = |(done_q & irq_en_q);

endmodule

// File: tb/tb_peripheral_esp_ctrl_multi.sv
// Self-checking bench for peripheral_esp_ctrl_multi: table of bus vectors, hand-written
// timing sequences, and randomized traffic compared against a timeline-based model.
module tb_peripheral_esp_ctrl_multi;

  localparam int N_CH      = 2;
  localparam int CNT_W     = 16;
  localparam int PULSE_DEF = 50;
  localparam int BOOT_DEF  = 100;

  localparam logic [3:0] A_CTRL   = 4'h0;
  localparam logic [3:0] A_STATUS = 4'h2;
  localparam logic [3:0] A_PULSE  = 4'h4;
  localparam logic [3:0] A_BOOT   = 4'h6;
  localparam logic [3:0] A_DONE   = 4'h8;
  localparam logic [3:0] A_IRQEN  = 4'hA;

  logic            clk = 1'b0;
  logic            sys_rst = 1'b1;
  logic            cs = 1'b0;
  logic            rd = 1'b0;
  logic            wr = 1'b0;
  logic [3:0]      addr = 4'h0;
  logic [15:0]     d_in = 16'h0;
  logic [15:0]     d_out;
  logic [N_CH-1:0] mod_rst;
  logic [N_CH-1:0] ready;
  logic            irq;

  peripheral_esp_ctrl_multi #(
    .N_CH(N_CH), .CNT_W(CNT_W), .PULSE_DEF(PULSE_DEF), .BOOT_DEF(BOOT_DEF)
  ) dut (
    .clk(clk), .sys_rst(sys_rst), .cs(cs), .rd(rd), .wr(wr), .addr(addr),
    .d_in(d_in), .d_out(d_out), .mod_rst(mod_rst), .ready(ready), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: each channel is described by the edge its sequence started on and
  // its effective pulse/boot lengths; outputs follow from the age of the sequence.
  int              edge_n = 0;
  int              ch_start [N_CH];
  int              ch_p     [N_CH];
  int              ch_b     [N_CH];
  int              m_pulse = PULSE_DEF;
  int              m_boot = BOOT_DEF;
  logic [N_CH-1:0] m_done = '0;
  logic [N_CH-1:0] m_irq_en = '0;
  logic [15:0]     m_dout = '0;

  int              fall_edge [N_CH];
  int              rise_edge [N_CH];
  logic [N_CH-1:0] prev_rst = '1;
  logic [N_CH-1:0] prev_rdy = '0;

  typedef struct {
    logic        c;
    logic        r;
    logic        w;
    logic [3:0]  a;
    logic [15:0] d;
    logic        chk;
    logic [15:0] dout;
  } vec_t;

  vec_t vecs [21];

  function automatic int maxone(int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int age(int i);
    return edge_n - ch_start[i];
  endfunction

  function automatic logic exp_rst(int i);
    return age(i) < ch_p[i];
  endfunction

  function automatic logic exp_rdy(int i);
    return age(i) >= ch_p[i] + ch_b[i];
  endfunction

  function automatic logic [15:0] model_read(logic [3:0] a);
    logic [15:0] v;
    v = '0;
    case (a)
      A_STATUS: begin
        for (int i = 0; i < N_CH; i++) begin
          v[i]     = exp_rdy(i);
          v[8 + i] = !exp_rdy(i);
        end
      end
      A_PULSE: v = 16'(m_pulse);
      A_BOOT:  v = 16'(m_boot);
      A_DONE:  v[N_CH-1:0] = m_done;
      A_IRQEN: v[N_CH-1:0] = m_irq_en;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_edge();
    logic [N_CH-1:0] starts;
    logic [N_CH-1:0] clrs;
    logic [N_CH-1:0] sets;
    if (sys_rst) begin
      edge_n++;
      for (int i = 0; i < N_CH; i++) begin
        ch_start[i] = edge_n;
        ch_p[i]     = maxone(PULSE_DEF);
        ch_b[i]     = maxone(BOOT_DEF);
      end
      m_pulse  = PULSE_DEF;
      m_boot   = BOOT_DEF;
      m_done   = '0;
      m_irq_en = '0;
      m_dout   = '0;
      return;
    end
    if (cs && rd) m_dout = model_read(addr);
    starts = (cs && wr && addr == A_CTRL) ? d_in[N_CH-1:0] : '0;
    clrs   = (cs && wr && addr == A_DONE) ? d_in[N_CH-1:0] : '0;
    edge_n++;
    sets = '0;
    for (int i = 0; i < N_CH; i++)
      if (!starts[i] && age(i) == ch_p[i] + ch_b[i]) sets[i] = 1'b1;
    m_done = (m_done & ~clrs) | sets;
    for (int i = 0; i < N_CH; i++) begin
      if (starts[i]) begin
        ch_start[i] = edge_n;
        ch_p[i]     = maxone(m_pulse);
        ch_b[i]     = maxone(m_boot);
      end
    end
    if (cs && wr) begin
      case (addr)
        A_PULSE: m_pulse  = int'(d_in);
        A_BOOT:  m_boot   = int'(d_in);
        A_IRQEN: m_irq_en = d_in[N_CH-1:0];
        default: ;
      endcase
    end
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at edge %0d", name, actual, expected, edge_n);
    end
  endtask

  // One clock edge: advance the model, then compare all outputs 1 time unit later.
  task automatic step();
    logic [15:0] em;
    logic [15:0] ey;
    @(posedge clk);
    model_edge();
    #1;
    em = '0;
    ey = '0;
    for (int i = 0; i < N_CH; i++) begin
      em[i] = exp_rst(i);
      ey[i] = exp_rdy(i);
    end
    checkOutput("mod_rst", 16'(mod_rst), em);
    checkOutput("ready", 16'(ready), ey);
    checkOutput("irq", 16'(irq), 16'(|(m_done & m_irq_en)));
    checkOutput("d_out", d_out, m_dout);
    for (int i = 0; i < N_CH; i++) begin
      if (prev_rst[i] && !mod_rst[i]) fall_edge[i] = edge_n;
      if (!prev_rdy[i] && ready[i]) rise_edge[i] = edge_n;
    end
    prev_rst = mod_rst;
    prev_rdy = ready;
  endtask

  task automatic applyStimulus(input logic s_rst, input logic s_cs, input logic s_rd,
                               input logic s_wr, input logic [3:0] s_addr,
                               input logic [15:0] s_data);
    sys_rst = s_rst;
    cs      = s_cs;
    rd      = s_rd;
    wr      = s_wr;
    addr    = s_addr;
    d_in    = s_data;
    step();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0);
  endtask

  task automatic busWrite(input logic [3:0] a, input logic [15:0] d);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, a, d);
  endtask

  task automatic busRead(input string name, input logic [3:0] a, input logic [15:0] exp);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, a, 16'h0);
    checkOutput(name, d_out, exp);
  endtask

  task automatic waitReady(input int ch, input int e_start);
    for (int n = 0; n < 2000 && !(rise_edge[ch] > e_start); n++) idle();
    checkOutput("ready_seen", 16'(rise_edge[ch] > e_start), 16'd1);
  endtask

  task automatic checkTiming(input string name, input int ch, input int e_start,
                             input int exp_pulse, input int exp_boot);
    checkOutput({name, "_pulse"}, 16'(fall_edge[ch] - e_start), 16'(exp_pulse));
    checkOutput({name, "_boot"}, 16'(rise_edge[ch] - fall_edge[ch]), 16'(exp_boot));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          e;
    int          sel;
    logic [3:0]  ra;
    logic        rc;
    logic        rr;
    logic        rw;
    logic [15:0] rdat;

    for (int i = 0; i < N_CH; i++) begin
      ch_start[i]  = 0;
      ch_p[i]      = 1;
      ch_b[i]      = 1;
      fall_edge[i] = -1;
      rise_edge[i] = -1;
    end

    vecs[0]  = '{1'b1, 1'b0, 1'b1, A_PULSE,  16'h1234, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, A_PULSE,  16'h0000, 1'b1, 16'h1234};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, A_BOOT,   16'hBEEF, 1'b0, 16'h0000};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, A_BOOT,   16'h0000, 1'b1, 16'hBEEF};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, A_IRQEN,  16'hFFFF, 1'b0, 16'h0000};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, A_IRQEN,  16'h0000, 1'b1, 16'h0003};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, A_PULSE,  16'h5555, 1'b1, 16'h0003};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, A_PULSE,  16'h0000, 1'b1, 16'h1234};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 4'hE,     16'h0000, 1'b1, 16'h0000};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, A_DONE,   16'h0000, 1'b1, 16'h0003};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 4'hC,     16'hFFFF, 1'b1, 16'h0003};
    vecs[11] = '{1'b1, 1'b1, 1'b0, A_IRQEN,  16'h0000, 1'b1, 16'h0003};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 4'h1,     16'h0000, 1'b1, 16'h0000};
    vecs[13] = '{1'b1, 1'b1, 1'b0, A_STATUS, 16'h0000, 1'b1, 16'h0003};
    vecs[14] = '{1'b1, 1'b1, 1'b0, A_CTRL,   16'h0000, 1'b1, 16'h0000};
    vecs[15] = '{1'b1, 1'b1, 1'b1, A_PULSE,  16'h0007, 1'b1, 16'h1234};
    vecs[16] = '{1'b1, 1'b1, 1'b0, A_PULSE,  16'h0000, 1'b1, 16'h0007};
    vecs[17] = '{1'b1, 1'b0, 1'b1, A_DONE,   16'h0001, 1'b0, 16'h0000};
    vecs[18] = '{1'b1, 1'b1, 1'b0, A_DONE,   16'h0000, 1'b1, 16'h0002};
    vecs[19] = '{1'b1, 1'b0, 1'b1, A_IRQEN,  16'h0000, 1'b0, 16'h0000};
    vecs[20] = '{1'b1, 1'b1, 1'b0, A_IRQEN,  16'h0000, 1'b1, 16'h0000};

    // Reset release: 50 cycles of mod_rst, 100 cycles of boot wait, DONE=3 afterwards.
    for (int n = 0; n < 5; n++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0);
    e = edge_n;
    checkOutput("rst_hold_mod_rst", 16'(mod_rst), 16'h0003);
    waitReady(0, e);
    waitReady(1, e);
    checkTiming("reset_ch0", 0, e, 50, 100);
    checkTiming("reset_ch1", 1, e, 50, 100);
    busRead("reset_done", A_DONE, 16'h0003);

    // Register-level vectors with both channels idle in READY.
    for (int v = 0; v < 21; v++) begin
      applyStimulus(1'b0, vecs[v].c, vecs[v].r, vecs[v].w, vecs[v].a, vecs[v].d);
      if (vecs[v].chk) checkOutput($sformatf("vec%0d_dout", v), d_out, vecs[v].dout);
      checkOutput($sformatf("vec%0d_ready", v), 16'(ready), 16'h0003);
    end

    // Short sequence on ch0, STATUS read while in RST, ch1 untouched.
    busWrite(A_PULSE, 16'd3);
    busWrite(A_BOOT, 16'd0);
    busWrite(A_CTRL, 16'h0001);
    e = edge_n;
    busRead("status_in_rst", A_STATUS, 16'h0102);
    waitReady(0, e);
    checkTiming("short_ch0", 0, e, 3, 1);
    checkOutput("ch1_unaffected", 16'(ready[1]), 16'd1);

    // Restart mid-RST reloads the pulse counter without a low glitch.
    busWrite(A_PULSE, 16'd10);
    busWrite(A_BOOT, 16'd2);
    busWrite(A_CTRL, 16'h0001);
    for (int n = 0; n < 3; n++) begin
      idle();
      checkOutput("restart_pre_hold", 16'(mod_rst[0]), 16'd1);
    end
    busWrite(A_CTRL, 16'h0001);
    e = edge_n;
    checkOutput("restart_no_glitch", 16'(mod_rst[0]), 16'd1);
    waitReady(0, e);
    checkTiming("restart_ch0", 0, e, 10, 2);

    // IRQ: raise on ch1 DONE, W1C clears it, then set and clear on the same edge.
    busWrite(A_DONE, 16'h0003);
    busWrite(A_IRQEN, 16'h0002);
    checkOutput("irq_idle", 16'(irq), 16'd0);
    busWrite(A_PULSE, 16'd3);
    busWrite(A_BOOT, 16'd2);
    busWrite(A_CTRL, 16'h0002);
    e = edge_n;
    waitReady(1, e);
    checkOutput("irq_raised", 16'(irq), 16'd1);
    busWrite(A_DONE, 16'h0002);
    checkOutput("irq_cleared", 16'(irq), 16'd0);
    busWrite(A_CTRL, 16'h0002);
    for (int n = 0; n < 4; n++) idle();
    busWrite(A_DONE, 16'h0002);
    checkOutput("set_wins_ready", 16'(ready[1]), 16'd1);
    checkOutput("set_wins_irq", 16'(irq), 16'd1);
    busRead("set_wins_done", A_DONE, 16'h0002);

    // BOOT_LEN change during RST does not affect the running sequence.
    busWrite(A_PULSE, 16'd4);
    busWrite(A_BOOT, 16'd20);
    busWrite(A_CTRL, 16'h0001);
    e = edge_n;
    busWrite(A_BOOT, 16'd5);
    waitReady(0, e);
    checkTiming("len_change_ch0", 0, e, 4, 20);

    // Zero lengths behave as one cycle each.
    busWrite(A_PULSE, 16'd0);
    busWrite(A_BOOT, 16'd0);
    busWrite(A_CTRL, 16'h0002);
    e = edge_n;
    waitReady(1, e);
    checkTiming("zero_len_ch1", 1, e, 1, 1);

    // Randomized bus traffic with occasional mid-sequence resets.
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 999);
      if (sel < 2) begin
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0);
      end else begin
        ra   = 4'($urandom_range(0, 15));
        rc   = ($urandom_range(0, 3) != 0);
        rr   = 1'($urandom_range(0, 1));
        rw   = 1'($urandom_range(0, 1));
        rdat = 16'($urandom_range(0, 15));
        if (ra == A_CTRL && $urandom_range(0, 7) != 0) rw = 1'b0;
        applyStimulus(1'b0, rc, rr, rw, ra, rdat);
      end
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
